// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, LFSR taps and BCD helper for the whack-a-mole engine
package game_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WIN = 2'd2, LOSE = 2'd3} state_t;
    localparam int TAP_A = 5;
    localparam int TAP_B = 3;
    localparam int TAP_C = 2;
    localparam int TAP_D = 0;
    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction
endpackage

// File: rtl/game_if.sv
// game_if: keypad/timebase inputs and display outputs of the game engine
interface game_if #(parameter int LANES = 9);
    import game_pkg::*;
    logic             tick;
    logic             start;
    logic             key_valid;
    logic [3:0]       key_idx;
    logic [LANES-1:0] mole_led;
    logic [7:0]       score_bcd;
    logic [7:0]       time_bcd;
    state_t           state;
    logic             done;
    modport master(output tick, start, key_valid, key_idx, input mole_led, score_bcd, time_bcd, state, done);
    modport slave(input tick, start, key_valid, key_idx, output mole_led, score_bcd, time_bcd, state, done);
endinterface

// File: rtl/game_lfsr.sv
// game_lfsr: 16-bit right-shifting Fibonacci LFSR that advances only when step is high
module game_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        step,
    output logic [15:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= SEED;
        else if (step) q <= {q[TAP_A] ^ q[TAP_B] ^ q[TAP_C] ^ q[TAP_D], q[15:1]};
    end
endmodule

// File: rtl/whack_game_core.sv
// whack_game_core: mole spawning, hit scoring, countdown and win/lose FSM
module whack_game_core
    import game_pkg::*;
#(
    parameter int          LANES        = 9,
    parameter int          TARGET       = 10,
    parameter int          TIME_LIMIT   = 30,
    parameter int          SPAWN_TICKS  = 1,
    parameter int          MISS_PENALTY = 0,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input logic  clk,
    input logic  rst_n,
    game_if.slave bus
);
    state_t           st;
    logic [6:0]       score, tm, n_score, n_tm;
    logic [15:0]      cnt, n_cnt, lfsr;
    logic [LANES-1:0] mole, raw, pat, mask, n_mole;
    logic             play, spawn, hit, miss, win, lose, step, done;

    game_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .step(step), .q(lfsr));

    always_comb begin
        play    = st == PLAY;
        raw     = LANES'(lfsr);
        pat     = raw == '0 ? LANES'(1) : raw;
        mask    = LANES'(1) << bus.key_idx;
        hit     = bus.key_valid && |(mole & mask);
        miss    = bus.key_valid && |mask && !hit;
        n_cnt   = bus.tick ? cnt + 16'd1 : cnt;
        spawn   = bus.tick && n_cnt == 16'(SPAWN_TICKS);
        n_tm    = bus.tick ? tm - 7'd1 : tm;
        n_score = hit ? (score == 7'd99 ? score : score + 7'd1)
                : (miss && MISS_PENALTY != 0 && score != 7'd0) ? score - 7'd1 : score;
        // a refresh overrides the cleared bit, but the hit was already scored
        n_mole  = spawn ? pat : hit ? mole & ~mask : mole;
        win     = n_score >= 7'(TARGET);
        lose    = !win && n_tm == 7'd0;
        step    = play ? spawn : bus.start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= IDLE;
            mole  <= '0;
            score <= '0;
            tm    <= 7'(TIME_LIMIT);
            cnt   <= '0;
            done  <= 1'b0;
        end else if (!play) begin
            if (bus.start) begin
                st    <= PLAY;
                mole  <= pat;
                score <= '0;
                tm    <= 7'(TIME_LIMIT);
                cnt   <= '0;
                done  <= 1'b0;
            end
        end else begin
            score <= n_score;
            tm    <= n_tm;
            cnt   <= spawn ? '0 : n_cnt;
            mole  <= (win || lose) ? '0 : n_mole;
            st    <= win ? WIN : lose ? LOSE : PLAY;
            done  <= win || lose;
        end
    end

    assign bus.mole_led  = mole;
    assign bus.score_bcd = bin2bcd(score);
    assign bus.time_bcd  = bin2bcd(tm);
    assign bus.state     = st;
    assign bus.done      = done;
endmodule

// File: tb/tb_whack_game_core.sv
// tb_whack_game_core: three differently configured engines driven together against a round-level model
module tb_whack_game_core;
    import game_pkg::*;
    logic       clk = 0, rst_n = 0, tick = 0, start = 0, kv = 0;
    logic [3:0] ki = 0;
    int         n_tot = 0, n_bad = 0;

    int P_L[3]  = '{9, 5, 16};
    int P_TG[3] = '{10, 2, 20};
    int P_TL[3] = '{30, 2, 40};
    int P_SP[3] = '{1, 1, 3};
    int P_MP[3] = '{0, 1, 1};
    int m_st[3], m_sc[3], m_tm[3], m_cnt[3], m_mole[3], m_l[3];

    game_if #(.LANES(9))  ia();
    game_if #(.LANES(5))  ib();
    game_if #(.LANES(16)) ic();
    assign ia.tick = tick;  assign ia.start = start;  assign ia.key_valid = kv;  assign ia.key_idx = ki;
    assign ib.tick = tick;  assign ib.start = start;  assign ib.key_valid = kv;  assign ib.key_idx = ki;
    assign ic.tick = tick;  assign ic.start = start;  assign ic.key_valid = kv;  assign ic.key_idx = ki;

    whack_game_core dut_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
    whack_game_core #(.LANES(5), .TARGET(2), .TIME_LIMIT(2), .SPAWN_TICKS(1), .MISS_PENALTY(1))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
    whack_game_core #(.LANES(16), .TARGET(20), .TIME_LIMIT(40), .SPAWN_TICKS(3), .MISS_PENALTY(1))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(ic.slave));

    always #5 clk = ~clk;

    function automatic int lfsr_next(int l);
        int fb = ((l >> 5) ^ (l >> 3) ^ (l >> 2) ^ l) & 1;
        return (l >> 1) | (fb << 15);
    endfunction

    function automatic int pattern(int l, int n);
        int p = l & ((1 << n) - 1);
        return p == 0 ? 1 : p;
    endfunction

    function automatic int bcd(int v);
        return (v / 10) * 16 + v % 10;
    endfunction

    function automatic int low_lane(int m);
        for (int i = 0; i < 16; i++) if ((m >> i) & 1) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_st[d] = 0; m_sc[d] = 0; m_tm[d] = P_TL[d]; m_cnt[d] = 0; m_mole[d] = 0; m_l[d] = 'hACE1;
        end
    endtask

    task automatic model_step();
        int k = int'(ki);
        for (int d = 0; d < 3; d++) begin
            if (m_st[d] != 1) begin
                if (start) begin
                    m_st[d] = 1; m_sc[d] = 0; m_tm[d] = P_TL[d]; m_cnt[d] = 0;
                    m_mole[d] = pattern(m_l[d], P_L[d]);
                    m_l[d] = lfsr_next(m_l[d]);
                end
            end else begin
                if (kv && k < P_L[d]) begin
                    if ((m_mole[d] >> k) & 1) begin
                        m_sc[d] = m_sc[d] < 99 ? m_sc[d] + 1 : 99;
                        m_mole[d] &= ~(1 << k);
                    end else if (P_MP[d] != 0 && m_sc[d] > 0) m_sc[d]--;
                end
                if (tick) begin
                    m_tm[d]--;
                    m_cnt[d]++;
                    if (m_cnt[d] == P_SP[d]) begin
                        m_cnt[d] = 0;
                        m_mole[d] = pattern(m_l[d], P_L[d]);
                        m_l[d] = lfsr_next(m_l[d]);
                    end
                end
                if (m_sc[d] >= P_TG[d]) begin m_st[d] = 2; m_mole[d] = 0; end
                else if (m_tm[d] == 0) begin m_st[d] = 3; m_mole[d] = 0; end
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_dut(int d, logic [15:0] mole, logic [7:0] sc, logic [7:0] tm, logic [1:0] st, logic dn);
        string s = $sformatf("dut%0d", d);
        chk({s, ".mole"}, 32'(mole), m_mole[d]);
        chk({s, ".score"}, 32'(sc), bcd(m_sc[d]));
        chk({s, ".time"}, 32'(tm), bcd(m_tm[d]));
        chk({s, ".state"}, 32'(st), m_st[d]);
        chk({s, ".done"}, 32'(dn), m_st[d] >= 2 ? 1 : 0);
    endtask

    task automatic check_all();
        chk_dut(0, 16'(ia.mole_led), ia.score_bcd, ia.time_bcd, ia.state, ia.done);
        chk_dut(1, 16'(ib.mole_led), ib.score_bcd, ib.time_bcd, ib.state, ib.done);
        chk_dut(2, ic.mole_led, ic.score_bcd, ic.time_bcd, ic.state, ic.done);
    endtask

    task automatic cycle(bit s, bit t, bit k, int idx);
        start = s; tick = t; kv = k; ki = 4'(idx);
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // entered at a falling edge; reset lands between edges and must act before the next one
    task automatic async_reset();
        #2 rst_n = 0;
        start = 0; tick = 0; kv = 0;
        #1 model_reset();
        check_all();
        chk("rst_mid_state", 32'(ia.state), 0);
        chk("rst_mid_time", 32'(ia.time_bcd), 'h30);
        @(negedge clk);
        rst_n = 1;
        #1 check_all();
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        #1 check_all();
        chk("rst_state", 32'(ia.state), 0);
        chk("rst_mole", 32'(ia.mole_led), 0);
        chk("rst_score", 32'(ia.score_bcd), 'h00);
        chk("rst_time", 32'(ia.time_bcd), 'h30);
        chk("rst_done", 32'(ia.done), 0);
        chk("rst_time_b", 32'(ib.time_bcd), 'h02);

        cycle(1, 0, 0, 0);
        chk("start_mole", 32'(ia.mole_led), 'h0E1);
        cycle(0, 0, 1, 0);
        chk("hit_mole", 32'(ia.mole_led), 'h0E0);
        chk("hit_score", 32'(ia.score_bcd), 'h01);
        cycle(0, 0, 1, 1);
        chk("miss_pen", 32'(ib.score_bcd), 'h00);
        chk("miss_nopen", 32'(ia.score_bcd), 'h01);
        cycle(0, 0, 1, 1);
        chk("miss_floor", 32'(ib.score_bcd), 'h00);
        cycle(0, 0, 1, 12);
        chk("key_oob", 32'(ib.score_bcd), 'h00);
        cycle(0, 0, 1, 0);
        chk("rehit", 32'(ia.score_bcd), 'h01);

        repeat (30) cycle(0, 1, 0, 0);
        chk("lose_state", 32'(ia.state), 3);
        chk("lose_time", 32'(ia.time_bcd), 'h00);
        chk("lose_mole", 32'(ia.mole_led), 0);
        chk("lose_done", 32'(ia.done), 1);
        repeat (4) cycle(0, 1, 1, $urandom_range(0, 15));
        chk("frozen_state", 32'(ia.state), 3);
        chk("frozen_score", 32'(ia.score_bcd), 'h01);
        chk("frozen_time", 32'(ia.time_bcd), 'h00);

        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, low_lane(m_mole[1]));
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, low_lane(m_mole[1]));
        chk("win_state", 32'(ib.state), 2);
        chk("win_score", 32'(ib.score_bcd), 'h02);
        chk("win_time", 32'(ib.time_bcd), 'h00);
        cycle(1, 0, 0, 0);
        chk("restart_state", 32'(ib.state), 1);
        chk("restart_score", 32'(ib.score_bcd), 'h00);
        chk("restart_time", 32'(ib.time_bcd), 'h02);

        cycle(0, 1, 0, 0);
        async_reset();
        cycle(1, 0, 0, 0);
        chk("reseed_mole", 32'(ia.mole_led), 'h0E1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) async_reset();
            else cycle($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0,
                       1'($urandom_range(0, 1)), $urandom_range(0, 15));
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/whack_game_core.md
Name: whack_game_core

Overview:
- Parametrised game engine for the whack-a-mole lab: LFSR-driven mole lanes, keypad hit detection, score, countdown timer, win/lose FSM.
- Sits between the keyboard decoder and debounced start button upstream, and the LED and 7-segment display drivers downstream.
- Runs entirely on the system clock; the 1-second timebase arrives as a single-cycle enable, not as a derived clock.
- Adds over the previous engine: configurable lane count, target and time; one score per hit with the mole cleared; optional miss penalty; BCD outputs.

Parameters:
LANES, 9, number of mole lanes/LEDs (1..16)
TARGET, 10, score that wins the round (1..99)
TIME_LIMIT, 30, round length in ticks (1..99)
SPAWN_TICKS, 1, ticks between mole-pattern refreshes (>=1)
MISS_PENALTY, 0, 1 = keypress on an unlit lane subtracts 1 point
SEED, 16'hACE1, LFSR reset value (nonzero)

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
tick  in  1  one-cycle 1 s enable
start  in  1  one-cycle start pulse (already debounced and one-pulsed)
key_valid  in  1  one-cycle pulse, new key press
key_idx  in  4  lane index of the pressed key
mole_led  out  LANES  lit lanes
score_bcd  out  8  score, two BCD digits
time_bcd  out  8  remaining ticks, two BCD digits
state  out  2  IDLE=0, PLAY=1, WIN=2, LOSE=3
done  out  1  high in WIN or LOSE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, mole_led=0, score=0, time=TIME_LIMIT, spawn_cnt=0, LFSR=SEED, done=0.
  - score_bcd=0x00; time_bcd=BCD(TIME_LIMIT).
  - Reset asserted mid-round aborts immediately to these values.
- LFSR:
  - 16-bit, right shift: next = {l[5]^l[3]^l[2]^l[0], l[15:1]}.
  - Steps only on a spawn event.
- IDLE/WIN/LOSE + start:
  - Next cycle: state=PLAY, score=0, time=TIME_LIMIT, spawn_cnt=0.
  - Load mole_led=LFSR[LANES-1:0], then step the LFSR. An all-zero pattern loads 1 (lane 0).
  - The LFSR is not reseeded.
- PLAY:
  - start is ignored.
  - On tick: time decrements by 1 and spawn_cnt increments. When spawn_cnt reaches SPAWN_TICKS, it clears, mole_led reloads from the LFSR (same zero rule), and the LFSR steps.
  - key_valid with key_idx < LANES:
    - Lit lane: score+1 (saturating at 99), and that mole bit clears.
    - Unlit lane with MISS_PENALTY=1: score-1, floored at 0.
    - Unlit lane with MISS_PENALTY=0: no effect.
  - key_idx >= LANES is ignored.
  - Latency: key or tick at cycle N, result visible at N+1.
  - Same-cycle key hit and spawn refresh: the refresh wins for mole_led; the score still counts if the pre-refresh bit was lit.
- Transitions out of PLAY (evaluated on next-state values):
  - next score >= TARGET -> WIN.
  - else next time == 0 -> LOSE.
  - A winning hit in the same cycle as the final tick gives WIN.
- WIN/LOSE:
  - mole_led=0, done=1.
  - Score and time freeze; keys and ticks are ignored.
- Width rules:
  - score and time held as 7-bit binary.
  - BCD conversion is combinational from registered binary, so outputs are registered-equivalent with no extra latency.

Decomposition:
- Shared package game_pkg:
  - state encoding constants (IDLE/PLAY/WIN/LOSE).
  - LFSR tap positions.
  - bin2bcd function (0..99 -> 8 bits).
- One sub-module, game_lfsr: parametrised SEED, step enable, 16-bit state output.
- FSM, counters, scoring and mole register stay in whack_game_core.

Test Plan:
1. Reset with defaults -> state=0, mole_led=0, score_bcd=0x00, time_bcd=0x30, done=0.
2. start, then key_idx=0 one cycle later -> mole_led 9'h0E1 becomes 9'h0E0; score_bcd=0x01. Repeat key_idx=0 -> score stays 0x01.
3. MISS_PENALTY=1, score 1:
   - key_idx=1 -> score_bcd=0x00.
   - key_idx=1 again -> stays 0x00.
   - key_idx=12 -> no change.
4. start with no keys, 30 ticks -> after the 30th tick, state=LOSE, time_bcd=0x00, mole_led=0, done=1. Further keys and ticks leave all outputs unchanged.
5. TARGET=2, TIME_LIMIT=2: first hit, then second hit in the same cycle as the 2nd tick -> state=WIN, score_bcd=0x02, time_bcd=0x00. A subsequent start gives PLAY with score 0x00 and time 0x02.
6. rst_n pulsed low mid-PLAY between clock edges -> outputs return to reset values immediately. After release, start reloads mole_led=9'h0E1 (LFSR back to SEED).
